// File: rtl/perf_pkg.sv
// perf_pkg: shared types and constants for the windowed utilization monitor
package perf_pkg;
    typedef enum logic {IDLE, RUN} perf_state_e;
    localparam int UTIL_W    = 7;
    localparam int PCT_SCALE = 100;
endpackage

// File: rtl/perf_util_divider.sv
// perf_util_divider: restoring divider, one quotient bit per cycle, fixed latency.
//  start    in   load num/den and begin; first bit is resolved in the start cycle
//  num/den  in   dividend / divisor (den must be non-zero)
//  quotient out  low Q_W bits of the quotient, valid while done=1 and held after
//  done     out  one-cycle pulse exactly NUM_W cycles after start
//  busy     out  high from the cycle after start through the done cycle
module perf_util_divider #(
    parameter int NUM_W = 39,
    parameter int DEN_W = 32,
    parameter int Q_W   = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic [Q_W-1:0]   quotient,
    output logic             done,
    output logic             busy
);
    localparam int CNT_W = $clog2(NUM_W + 1);
    logic [NUM_W-1:0] q, q_in, q_step;
    logic [DEN_W-1:0] rem, rem_in, rem_step, den_q, den_in;
    logic [DEN_W:0]   shifted, diff;
    logic [CNT_W-1:0] cnt;
    // The partial remainder stays below den, so diff's top bit is a pure sign bit.
    always_comb begin
        q_in     = start ? num : q;
        rem_in   = start ? '0 : rem;
        den_in   = start ? den : den_q;
        shifted  = {rem_in, q_in[NUM_W-1]};
        diff     = shifted - {1'b0, den_in};
        rem_step = diff[DEN_W] ? shifted[DEN_W-1:0] : diff[DEN_W-1:0];
        q_step   = {q_in[NUM_W-2:0], ~diff[DEN_W]};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q     <= '0;
            rem   <= '0;
            den_q <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            if (start || cnt != '0) begin
                q   <= q_step;
                rem <= rem_step;
            end
            if (start)
                den_q <= den;
            cnt  <= start ? CNT_W'(NUM_W - 1) : (cnt != '0 ? cnt - CNT_W'(1) : cnt);
            done <= !start && cnt == CNT_W'(1);
        end
    end
    assign quotient = q[Q_W-1:0];
    assign busy     = cnt != '0 || done;
endmodule

// File: rtl/perf_window_ctrl.sv
// perf_window_ctrl: windowed busy/idle measurement with utilization result on valid/ready.
//  start/stop/continuous   window control pulses and mode (mode sampled at start)
//  window_len/src_sel      window length and busy source, sampled at start
//  busy_in                 per-source busy flags
//  active                  high while a window is running
//  res_valid/res_ready     result handshake; res_* stable while res_valid=1
//  res_total/busy/idle     cycle counts of the published window
//  res_util                floor(busy*100/total)
//  overrun                 sticky: a window was dropped or a result overwritten
module perf_window_ctrl
    import perf_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int NUM_SOURCES   = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           continuous,
    input  logic [COUNTER_WIDTH-1:0]       window_len,
    input  logic [$clog2(NUM_SOURCES)-1:0] src_sel,
    input  logic [NUM_SOURCES-1:0]         busy_in,
    output logic                           active,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [COUNTER_WIDTH-1:0]       res_total,
    output logic [COUNTER_WIDTH-1:0]       res_busy,
    output logic [COUNTER_WIDTH-1:0]       res_idle,
    output logic [UTIL_W-1:0]              res_util,
    output logic                           overrun
);
    localparam int CW = COUNTER_WIDTH;
    localparam int NW = CW + UTIL_W;
    perf_state_e state;
    logic [CW-1:0] len_q, total_cnt, busy_cnt, busy_next, div_total, div_busy;
    logic [$clog2(NUM_SOURCES)-1:0] src_q;
    logic cont_q, arm, win_end, counting, div_start, div_run, div_done;
    logic [NW-1:0] div_num;
    logic [UTIL_W-1:0] quotient;
    // busy_next/win_end fold the current cycle's sample into the window that ends now.
    always_comb begin
        arm       = state == IDLE && start && !stop && window_len != '0;
        busy_next = busy_cnt + CW'(busy_in[src_q]);
        win_end   = state == RUN && !stop && total_cnt + CW'(1) == len_q;
        counting  = state == RUN && !stop && !win_end;
        div_start = win_end && !div_run;
        div_num   = NW'(busy_next) * NW'(PCT_SCALE);
    end
    perf_util_divider #(.NUM_W(NW), .DEN_W(CW), .Q_W(UTIL_W)) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .num      (div_num),
        .den      (len_q),
        .quotient (quotient),
        .done     (div_done),
        .busy     (div_run)
    );
    assign active = state == RUN;
    // Counts for the in-flight divide are parked so a following window can run meanwhile.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            len_q     <= '0;
            src_q     <= '0;
            cont_q    <= 1'b0;
            total_cnt <= '0;
            busy_cnt  <= '0;
            div_total <= '0;
            div_busy  <= '0;
            res_valid <= 1'b0;
            res_total <= '0;
            res_busy  <= '0;
            res_idle  <= '0;
            res_util  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (arm) begin
                state  <= RUN;
                len_q  <= window_len;
                src_q  <= src_sel;
                cont_q <= continuous;
            end else if (state == RUN && stop) begin
                state  <= IDLE;
                cont_q <= 1'b0;
            end else if (win_end && !cont_q) begin
                state <= IDLE;
            end
            total_cnt <= counting ? total_cnt + CW'(1) : '0;
            busy_cnt  <= counting ? busy_next : '0;
            if (div_start) begin
                div_total <= len_q;
                div_busy  <= busy_next;
            end
            if (div_done) begin
                res_valid <= 1'b1;
                res_total <= div_total;
                res_busy  <= div_busy;
                res_idle  <= div_total - div_busy;
                res_util  <= quotient;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            overrun <= (div_done && res_valid && !res_ready) || (win_end && div_run) || (overrun && !arm);
        end
    end
endmodule
